// File: rtl/ibuffer_mp_if.sv
// Purpose: handshake/bus bundle between predecode, ibuffer_mp and decode.
// Ports: flush, in_en/in_inst/in_fsqIdx/in_ready (enqueue side),
//        out_valid/out_inst/out_fsqIdx/out_ready (decode side), count.
interface ibuffer_mp_if #(
    parameter int ENQ_WIDTH  = 4,
    parameter int DEQ_WIDTH  = 4,
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 6
);
    logic                            flush;
    logic [ENQ_WIDTH-1:0]            in_en;
    logic [ENQ_WIDTH*DATA_WIDTH-1:0] in_inst;
    logic [IDX_WIDTH-1:0]            in_fsqIdx;
    logic                            in_ready;
    logic [DEQ_WIDTH-1:0]            out_valid;
    logic [DEQ_WIDTH*DATA_WIDTH-1:0] out_inst;
    logic [DEQ_WIDTH*IDX_WIDTH-1:0]  out_fsqIdx;
    logic                            out_ready;
    logic [$clog2(DEPTH):0]          count;

    modport master (
        output flush, in_en, in_inst, in_fsqIdx, out_ready,
        input  in_ready, out_valid, out_inst, out_fsqIdx, count
    );

    modport slave (
        input  flush, in_en, in_inst, in_fsqIdx, out_ready,
        output in_ready, out_valid, out_inst, out_fsqIdx, count
    );
endinterface

// File: rtl/ibuffer_mp.sv
// Purpose: multi-port instruction buffer; compacts sparse enqueue lanes in
// program order into a circular queue and presents the oldest DEQ_WIDTH
// entries to decode. Optional same-cycle empty bypass: `define IBUF_BYPASS_EN.
// Ports: clk, rst (sync, active-high), bus (ibuffer_mp_if.slave).
module ibuffer_mp #(
    parameter int ENQ_WIDTH  = 4,
    parameter int DEQ_WIDTH  = 4,
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 6
) (
    input  logic          clk,
    input  logic          rst,
    ibuffer_mp_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] r_inst [DEPTH];
    logic [IDX_WIDTH-1:0]  r_idx  [DEPTH];
    logic [AW-1:0]         r_head;
    logic [AW-1:0]         r_tail;
    logic [CW-1:0]         r_count;

    logic [CW-1:0]         w_pos [ENQ_WIDTH];
    logic [CW-1:0]         w_pop;
    logic                  w_in_ready;
    logic                  w_enq;
    logic [CW-1:0]         w_enq_num;
    logic [CW-1:0]         w_vis_num;
    logic [CW-1:0]         w_deq_num;
    logic [CW:0]           w_count_wide;

    logic [DEQ_WIDTH-1:0]            w_q_valid;
    logic [DEQ_WIDTH*DATA_WIDTH-1:0] w_q_inst;
    logic [DEQ_WIDTH*IDX_WIDTH-1:0]  w_q_idx;

    // w_pos[j]: rank of lane j among the set lanes below it (compaction slot)
    always_comb begin
        w_pop = '0;
        for (int j = 0; j < ENQ_WIDTH; j++) begin
            w_pos[j] = w_pop;
            w_pop    = w_pop + CW'(bus.in_en[j]);
        end
    end

    assign w_in_ready = (CW'(DEPTH) - r_count) >= CW'(ENQ_WIDTH);
    assign w_enq      = w_in_ready && (|bus.in_en);
    assign w_enq_num  = w_enq ? w_pop : '0;

    always_comb begin
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            w_q_valid[i] = r_count > CW'(i);
            w_q_inst[i*DATA_WIDTH +: DATA_WIDTH] = r_inst[r_head + AW'(i)];
            w_q_idx[i*IDX_WIDTH +: IDX_WIDTH]    = r_idx[r_head + AW'(i)];
        end
    end

`ifdef IBUF_BYPASS_EN
    logic                            w_byp;
    logic [DEQ_WIDTH-1:0]            w_b_valid;
    logic [DEQ_WIDTH*DATA_WIDTH-1:0] w_b_inst;

    assign w_byp = (r_count == '0) && !bus.flush;

    // Same compaction as the write path, but routed straight to decode
    always_comb begin
        w_b_inst = '0;
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            w_b_valid[i] = w_enq_num > CW'(i);
            for (int j = 0; j < ENQ_WIDTH; j++) begin
                if (bus.in_en[j] && (w_pos[j] == CW'(i))) begin
                    w_b_inst[i*DATA_WIDTH +: DATA_WIDTH] =
                        bus.in_inst[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        if (w_byp) begin
            bus.out_valid  = w_b_valid;
            bus.out_inst   = w_b_inst;
            bus.out_fsqIdx = {DEQ_WIDTH{bus.in_fsqIdx}};
            w_vis_num      = (w_enq_num > CW'(DEQ_WIDTH)) ?
                             CW'(DEQ_WIDTH) : w_enq_num;
        end else begin
            bus.out_valid  = w_q_valid;
            bus.out_inst   = w_q_inst;
            bus.out_fsqIdx = w_q_idx;
            w_vis_num      = (r_count > CW'(DEQ_WIDTH)) ?
                             CW'(DEQ_WIDTH) : r_count;
        end
    end
`else
    assign bus.out_valid  = w_q_valid;
    assign bus.out_inst   = w_q_inst;
    assign bus.out_fsqIdx = w_q_idx;
    assign w_vis_num      = (r_count > CW'(DEQ_WIDTH)) ?
                            CW'(DEQ_WIDTH) : r_count;
`endif

    assign w_deq_num    = bus.out_ready ? w_vis_num : '0;
    // In bypass mode the consumed lanes are still written, but head skips
    // past them, so only the remainder stays visible.
    assign w_count_wide = {1'b0, r_count} + {1'b0, w_enq_num}
                        - {1'b0, w_deq_num};

    assign bus.in_ready = w_in_ready;
    assign bus.count    = r_count;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            assert (w_count_wide <= (CW+1)'(DEPTH));
            r_head  <= r_head + w_deq_num[AW-1:0];
            r_tail  <= r_tail + w_enq_num[AW-1:0];
            r_count <= w_count_wide[CW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !bus.flush && w_enq) begin
            for (int j = 0; j < ENQ_WIDTH; j++) begin
                if (bus.in_en[j]) begin
                    r_inst[r_tail + w_pos[j][AW-1:0]] <=
                        bus.in_inst[j*DATA_WIDTH +: DATA_WIDTH];
                    r_idx[r_tail + w_pos[j][AW-1:0]] <= bus.in_fsqIdx;
                end
            end
        end
    end
endmodule

// File: tb/tb_ibuffer_mp.sv
// Purpose: directed self-checking bench for ibuffer_mp (reset, compaction,
// fill/drop, streaming wrap, flush, bypass or 1-cycle latency).
module tb_ibuffer_mp;
    localparam int EW = 4;
    localparam int DW = 4;
    localparam int DP = 16;
    localparam int XW = 32;
    localparam int IW = 6;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   q[$];
    int   v;

    always #5 clk = ~clk;

    ibuffer_mp_if #(.ENQ_WIDTH(EW), .DEQ_WIDTH(DW), .DEPTH(DP),
                    .DATA_WIDTH(XW), .IDX_WIDTH(IW)) bus ();

    ibuffer_mp #(.ENQ_WIDTH(EW), .DEQ_WIDTH(DW), .DEPTH(DP),
                 .DATA_WIDTH(XW), .IDX_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lane(input int i);
        return bus.out_inst[i*XW +: XW];
    endfunction

    function automatic logic [5:0] lidx(input int i);
        return bus.out_fsqIdx[i*IW +: IW];
    endfunction

    task automatic group(input int base);
        bus.in_en = 4'b1111;
        for (int l = 0; l < EW; l++) bus.in_inst[l*XW +: XW] = base + l;
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.in_en = '0;
        bus.in_inst = '0;
        bus.in_fsqIdx = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_ready", 64'(bus.in_ready), 64'd1);

        // sparse lanes: lane3=D, lane2 idle, lane1=B, lane0=A
        bus.in_en = 4'b1011;
        bus.in_inst = {32'hDDDD, 32'hEEEE, 32'hBBBB, 32'hAAAA};
        bus.in_fsqIdx = 6'd5;
        tick();
        bus.in_en = '0;
        #1;
        chk("cmp_count", 64'(bus.count), 64'd3);
        chk("cmp_valid", 64'(bus.out_valid), 64'b0111);
        chk("cmp_l0", 64'(lane(0)), 64'hAAAA);
        chk("cmp_l1", 64'(lane(1)), 64'hBBBB);
        chk("cmp_l2", 64'(lane(2)), 64'hDDDD);
        chk("cmp_i0", 64'(lidx(0)), 64'd5);
        chk("cmp_i1", 64'(lidx(1)), 64'd5);
        chk("cmp_i2", 64'(lidx(2)), 64'd5);

        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("clr_count", 64'(bus.count), 64'd0);

        // fill to full, then a dropped fifth group
        bus.in_fsqIdx = 6'd1;
        for (int g = 0; g < 4; g++) begin
            group(32'h100 + 4*g);
            tick();
            chk("fill_count", 64'(bus.count), 64'(4*(g+1)));
        end
        chk("full_ready", 64'(bus.in_ready), 64'd0);
        group(32'h900);
        tick();
        bus.in_en = '0;
        chk("drop_count", 64'(bus.count), 64'd16);
        chk("drop_head", 64'(lane(0)), 64'h100);

        // drain to 8
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("drain_count", 64'(bus.count), 64'd8);
        for (int k = 8; k < 16; k++) q.push_back(32'h100 + k);

        // 20 cycles streaming enq+deq at count 8, wrapping head/tail
        for (int c = 0; c < 20; c++) begin
            group(32'h200 + 4*c);
            for (int l = 0; l < EW; l++) q.push_back(32'h200 + 4*c + l);
            for (int i = 0; i < DW; i++) begin
                v = q.pop_front();
                chk("stream_lane", 64'(lane(i)), 64'(v));
            end
            tick();
        end
        bus.in_en = '0;
        chk("stream_count", 64'(bus.count), 64'd8);
        chk("stream_next", 64'(lane(0)), 64'(q[0]));

        // drain, then build count=10
        tick();
        tick();
        bus.out_ready = 1'b0;
        chk("empty_count", 64'(bus.count), 64'd0);
        group(32'h300);
        tick();
        group(32'h304);
        tick();
        bus.in_en = 4'b0011;
        tick();
        chk("ten_count", 64'(bus.count), 64'd10);

        // flush beats same-cycle enqueue and dequeue
        bus.flush = 1'b1;
        group(32'h400);
        bus.out_ready = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.in_en = '0;
        chk("flush_count", 64'(bus.count), 64'd0);
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_ready", 64'(bus.in_ready), 64'd1);
        tick();
        chk("noop_count", 64'(bus.count), 64'd0);

        // empty queue, full group with out_ready
        bus.in_fsqIdx = 6'd9;
        group(32'h500);
        #1;
`ifdef IBUF_BYPASS_EN
        chk("byp_valid", 64'(bus.out_valid), 64'b1111);
        for (int i = 0; i < DW; i++)
            chk("byp_lane", 64'(lane(i)), 64'(32'h500 + i));
        tick();
        bus.in_en = '0;
        bus.out_ready = 1'b0;
        chk("byp_count", 64'(bus.count), 64'd0);
`else
        chk("lat_valid0", 64'(bus.out_valid), 64'd0);
        tick();
        bus.in_en = '0;
        bus.out_ready = 1'b0;
        #1;
        chk("lat_valid1", 64'(bus.out_valid), 64'b1111);
        chk("lat_count", 64'(bus.count), 64'd4);
        for (int i = 0; i < DW; i++)
            chk("lat_lane", 64'(lane(i)), 64'(32'h500 + i));
        chk("lat_idx", 64'(lidx(3)), 64'd9);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
